regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, width of write data.
REQ-002 Parameter REG_ADDR_W, default 2, register address width (2**REG_ADDR_W registers).
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Hold  input  1  pipeline freeze; blocks new grants.
REQ-006 A_Valid  input  1  ALU writeback request.
REQ-007 A_RD  input  REG_ADDR_W  ALU destination register.
REQ-008 A_Data  input  DATA_W  ALU write data.
REQ-009 A_Ready  output  1  ALU request accepted this cycle.
REQ-010 B_Valid, B_RD, B_Data, B_Ready: same widths and meaning as A_*, for the load unit.
REQ-011 RD  output  REG_ADDR_W  register-file write address.
REQ-012 WriteData  output  DATA_W  register-file write data.
REQ-013 RegWrite  output  1  register-file write enable.
REQ-014 Busy  output  2**REG_ADDR_W  one-hot decode of RD, gated by RegWrite.
REQ-015 ConflictCount  output  8  saturating count of contended cycles.

Function
REQ-016 Transfer on a port occurs when Valid and Ready are both 1 in the same cycle.
REQ-017 At most one transfer per cycle; A_Ready and B_Ready are never 1 together.
REQ-018 Hold=1 or Reset=1 forces A_Ready=B_Ready=0.
REQ-019 Only one Valid high: that port gets Ready=1.
REQ-020 Both Valid high: grant goes to the port not recorded in LastGnt (round-robin).
REQ-021 LastGnt updates to the granted port on every transfer and holds otherwise.
REQ-022 Ready is combinational from Valid, Hold and LastGnt; the Valid inputs have no combinational path to RD, WriteData or RegWrite.
REQ-023 Transfer in cycle N: RD and WriteData take the granted RD/Data, and RegWrite=1 during cycle N+1.
REQ-024 No transfer in cycle N: RegWrite=0 in cycle N+1, and RD and WriteData hold their previous values.
REQ-025 Latency is one cycle from acceptance to RegWrite; the register file is updated at the end of cycle N+1.
REQ-026 A requester must hold Valid, RD and Data stable until its transfer.
REQ-027 Both requesters targeting the same RD: writes are issued in grant order on consecutive cycles, and the later grant's data is final.
REQ-028 ConflictCount increments by 1 in each cycle with A_Valid=B_Valid=1 and Hold=0.
REQ-029 ConflictCount saturates at 255 and does not wrap.
REQ-030 Hold asserted while RegWrite=1: the already-registered write still completes, and RegWrite is 0 the following cycle.
REQ-031 Busy[i]=1 exactly when RegWrite=1 and RD=i.

Reset
REQ-032 Reset=1 at a rising edge sets RegWrite=0, RD=0, WriteData=0, ConflictCount=0 and LastGnt=B.
REQ-033 After reset, the first contended cycle grants port A.
REQ-034 Reset asserted while RegWrite=1 drops RegWrite in the next cycle; the pending write is discarded, and no requester is acknowledged in the reset cycle.

Structure
REQ-035 Shared package cpu16_pkg holds DATA_W and REG_ADDR_W defaults plus the requester-ID constants GNT_A=0 and GNT_B=1.
REQ-036 The grant logic is one sub-module, rr_arbiter2 (inputs: two requests, enable; outputs: two one-hot grants; contains the LastGnt flop).
REQ-037 Output registers, Busy decode and ConflictCount live in the top module.

Verification
REQ-038 Reset, then A_Valid=1, A_RD=2, A_Data=16'h1234 for one cycle -> A_Ready=1; next cycle RegWrite=1, RD=2, WriteData=16'h1234, Busy=4'b0100; RegFile reg 2 reads 16'h1234 afterward.
REQ-039 Both Valid for 4 cycles (A_RD=1, B_RD=3) -> grant order A,B,A,B; RegWrite=1 for 4 consecutive cycles; ConflictCount=3 after the final contended cycle and 4 after the next edge.
REQ-040 A and B both to RD=0 (A_Data=16'hAAAA, B_Data=16'h5555) after reset -> A written first, then B; reg 0 ends at 16'h5555.
REQ-041 Hold=1 with both Valid for 10 cycles -> no Ready and RegWrite=0 throughout; ConflictCount unchanged; Hold=0 -> A granted first.
REQ-042 Force 300 contended cycles -> ConflictCount=255 and does not wrap.
REQ-043 Reset pulsed in the cycle after a transfer -> RegWrite=0 in the following cycle, target register unchanged, all outputs at reset values.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared widths and requester IDs for the register-file writeback path.
package cpu16_pkg;
   localparam int   DATA_W_DEF     = 16;
   localparam int   REG_ADDR_W_DEF = 2;
   localparam logic GNT_A          = 1'b0;
   localparam logic GNT_B          = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; last_gnt remembers who won the last transfer.
module rr_arbiter2
   import cpu16_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic en,
   output logic gnt_a,
   output logic gnt_b
);
   logic last_gnt;

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (en) begin
         if (req_a && req_b) begin
            // contended: favour whoever did not win last time
            gnt_a = (last_gnt == GNT_B);
            gnt_b = (last_gnt == GNT_A);
         end else begin
            gnt_a = req_a;
            gnt_b = req_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         last_gnt <= GNT_B;
      else if (gnt_a)
         last_gnt <= GNT_A;
      else if (gnt_b)
         last_gnt <= GNT_B;
   end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load-unit writebacks into one register-file write port,
// one cycle after acceptance, with a saturating contention counter.
module regfile_write_arbiter
   import cpu16_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       Hold,
   input  logic                       A_Valid,
   input  logic [REG_ADDR_W-1:0]      A_RD,
   input  logic [DATA_W-1:0]          A_Data,
   output logic                       A_Ready,
   input  logic                       B_Valid,
   input  logic [REG_ADDR_W-1:0]      B_RD,
   input  logic [DATA_W-1:0]          B_Data,
   output logic                       B_Ready,
   output logic [REG_ADDR_W-1:0]      RD,
   output logic [DATA_W-1:0]          WriteData,
   output logic                       RegWrite,
   output logic [(1<<REG_ADDR_W)-1:0] Busy,
   output logic [7:0]                 ConflictCount
);
   logic en, gnt_a, gnt_b, contend;

   assign en      = ~Hold & ~Reset;
   assign contend = A_Valid & B_Valid & ~Hold;

   rr_arbiter2 u_arb (
      .clk   (Clock),
      .rst   (Reset),
      .req_a (A_Valid),
      .req_b (B_Valid),
      .en    (en),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b)
   );

   assign A_Ready = gnt_a;
   assign B_Ready = gnt_b;

   // Only the grants reach the write registers, so Valid never feeds RD/data combinationally.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         RegWrite  <= 1'b0;
         RD        <= '0;
         WriteData <= '0;
      end else begin
         RegWrite <= gnt_a | gnt_b;
         if (gnt_a) begin
            RD        <= A_RD;
            WriteData <= A_Data;
         end else if (gnt_b) begin
            RD        <= B_RD;
            WriteData <= B_Data;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset)
         ConflictCount <= 8'd0;
      else if (contend && ConflictCount != 8'hFF)
         ConflictCount <= ConflictCount + 8'd1;
   end

   always_comb begin
      Busy = '0;
      if (RegWrite)
         Busy[RD] = 1'b1;
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a small reset-aware register file model.
module tb_regfile_write_arbiter;
   logic        Clock = 1'b0;
   logic        Reset, Hold;
   logic        A_Valid, B_Valid, A_Ready, B_Ready;
   logic [1:0]  A_RD, B_RD, RD;
   logic [15:0] A_Data, B_Data, WriteData;
   logic        RegWrite;
   logic [3:0]  Busy;
   logic [7:0]  ConflictCount;
   logic [15:0] rf [4];
   int          checks = 0;
   int          errors = 0;

   regfile_write_arbiter #(.DATA_W(16), .REG_ADDR_W(2)) dut (
      .Clock(Clock), .Reset(Reset), .Hold(Hold),
      .A_Valid(A_Valid), .A_RD(A_RD), .A_Data(A_Data), .A_Ready(A_Ready),
      .B_Valid(B_Valid), .B_RD(B_RD), .B_Data(B_Data), .B_Ready(B_Ready),
      .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
      .Busy(Busy), .ConflictCount(ConflictCount)
   );

   always #5 Clock = ~Clock;

   // a write still pending when reset hits is dropped
   always @(posedge Clock)
      if (RegWrite && !Reset) rf[RD] <= WriteData;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) rf[i] = 16'h0;
      Reset = 1'b1; Hold = 1'b0;
      A_Valid = 1'b1; A_RD = 2'd0; A_Data = 16'h0;
      B_Valid = 1'b1; B_RD = 2'd0; B_Data = 16'h0;
      tick(); tick();
      chk("rst_ready_a", A_Ready, 0);
      chk("rst_ready_b", B_Ready, 0);
      chk("rst_regwrite", RegWrite, 0);
      chk("rst_rd", RD, 0);
      chk("rst_wdata", WriteData, 0);
      chk("rst_cc", ConflictCount, 0);
      chk("rst_busy", Busy, 0);
      A_Valid = 1'b0; B_Valid = 1'b0; Reset = 1'b0;

      // single ALU write
      A_Valid = 1'b1; A_RD = 2'd2; A_Data = 16'h1234;
      #1;
      chk("t1_ready_a", A_Ready, 1);
      chk("t1_ready_b", B_Ready, 0);
      tick(); A_Valid = 1'b0; #1;
      chk("t1_regwrite", RegWrite, 1);
      chk("t1_rd", RD, 2);
      chk("t1_wdata", WriteData, 16'h1234);
      chk("t1_busy", Busy, 4'b0100);
      tick();
      chk("t1_regwrite_off", RegWrite, 0);
      chk("t1_rd_hold", RD, 2);
      chk("t1_wdata_hold", WriteData, 16'h1234);
      chk("t1_busy_off", Busy, 0);
      chk("t1_rf2", rf[2], 16'h1234);

      // round-robin under sustained contention
      Reset = 1'b1; tick(); Reset = 1'b0;
      A_Valid = 1'b1; A_RD = 2'd1; A_Data = 16'h1111;
      B_Valid = 1'b1; B_RD = 2'd3; B_Data = 16'h3333;
      #1;
      chk("t2_c1_a", A_Ready, 1);
      chk("t2_c1_b", B_Ready, 0);
      chk("t2_c1_cc", ConflictCount, 0);
      tick();
      chk("t2_c2_b", B_Ready, 1);
      chk("t2_c2_a", A_Ready, 0);
      chk("t2_c2_rd", RD, 1);
      chk("t2_c2_wd", WriteData, 16'h1111);
      chk("t2_c2_cc", ConflictCount, 1);
      tick();
      chk("t2_c3_a", A_Ready, 1);
      chk("t2_c3_rd", RD, 3);
      chk("t2_c3_wd", WriteData, 16'h3333);
      chk("t2_c3_we", RegWrite, 1);
      tick();
      chk("t2_c4_b", B_Ready, 1);
      chk("t2_c4_rd", RD, 1);
      chk("t2_c4_cc", ConflictCount, 3);
      chk("t2_c4_we", RegWrite, 1);
      tick(); A_Valid = 1'b0; B_Valid = 1'b0; #1;
      chk("t2_c5_we", RegWrite, 1);
      chk("t2_c5_rd", RD, 3);
      chk("t2_c5_cc", ConflictCount, 4);
      tick();
      chk("t2_c6_we", RegWrite, 0);
      chk("t2_c6_cc", ConflictCount, 4);

      // same destination: grant order decides the final value
      Reset = 1'b1; tick(); Reset = 1'b0;
      A_Valid = 1'b1; A_RD = 2'd0; A_Data = 16'hAAAA;
      B_Valid = 1'b1; B_RD = 2'd0; B_Data = 16'h5555;
      #1;
      chk("t3_a_first", A_Ready, 1);
      tick(); A_Valid = 1'b0; #1;
      chk("t3_wd_a", WriteData, 16'hAAAA);
      chk("t3_b_next", B_Ready, 1);
      tick(); B_Valid = 1'b0; #1;
      chk("t3_wd_b", WriteData, 16'h5555);
      chk("t3_rd", RD, 0);
      chk("t3_we", RegWrite, 1);
      tick();
      chk("t3_rf0", rf[0], 16'h5555);
      chk("t3_we_off", RegWrite, 0);

      // hold freezes grants; an already-registered write still lands
      Reset = 1'b1; tick(); Reset = 1'b0;
      B_Valid = 1'b1; B_RD = 2'd3; B_Data = 16'hBEEF;
      tick();
      Hold = 1'b1;
      A_Valid = 1'b1; A_RD = 2'd1; A_Data = 16'hCAFE;
      B_Valid = 1'b1; B_RD = 2'd2; B_Data = 16'hD00D;
      #1;
      chk("t4_pending_we", RegWrite, 1);
      chk("t4_pending_rd", RD, 3);
      chk("t4_hold_a", A_Ready, 0);
      chk("t4_hold_b", B_Ready, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_hold_we", RegWrite, 0);
         chk("t4_hold_rdy", {A_Ready, B_Ready}, 0);
         chk("t4_hold_cc", ConflictCount, 0);
      end
      chk("t4_rf3", rf[3], 16'hBEEF);
      Hold = 1'b0; #1;
      chk("t4_rel_a", A_Ready, 1);
      chk("t4_rel_b", B_Ready, 0);
      tick();
      chk("t4_rel_wd", WriteData, 16'hCAFE);
      chk("t4_rel_cc", ConflictCount, 1);
      chk("t4_rel_b2", B_Ready, 1);
      tick(); A_Valid = 1'b0; B_Valid = 1'b0; #1;
      chk("t4_rel_wd2", WriteData, 16'hD00D);
      chk("t4_busy", Busy, 4'b0100);

      // saturation of the contention counter
      Reset = 1'b1; tick(); Reset = 1'b0;
      A_Valid = 1'b1; B_Valid = 1'b1;
      for (int i = 0; i < 254; i++) tick();
      chk("t5_cc_254", ConflictCount, 254);
      for (int i = 0; i < 46; i++) tick();
      chk("t5_cc_sat", ConflictCount, 255);
      tick();
      chk("t5_cc_nowrap", ConflictCount, 255);
      A_Valid = 1'b0; B_Valid = 1'b0;
      tick();

      // reset in the cycle after a transfer discards the pending write
      A_Valid = 1'b1; A_RD = 2'd3; A_Data = 16'h7777;
      tick();
      Reset = 1'b1; #1;
      chk("t6_we_pending", RegWrite, 1);
      chk("t6_rst_no_ack", A_Ready, 0);
      tick();
      chk("t6_we", RegWrite, 0);
      chk("t6_rd", RD, 0);
      chk("t6_wd", WriteData, 0);
      chk("t6_busy", Busy, 0);
      chk("t6_cc", ConflictCount, 0);
      chk("t6_rf3", rf[3], 16'hBEEF);
      Reset = 1'b0; B_Valid = 1'b1; #1;
      chk("t6_first_a", A_Ready, 1);
      chk("t6_first_b", B_Ready, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
